pixel_unpacker: RTL and testbench

- AXI-Stream slave that consumes the packed 24-bit-per-pixel video stream produced by the pixel generator's packer: 4 pixels in 3 32-bit words, with tuser marking start-of-frame and tlast marking end-of-line.
- Emits one RGB pixel per handshake, with x/y coordinates and SOF/EOL flags, to a downstream pixel consumer such as a frame checker or a framebuffer writer.
- Checks the framing markers and resynchronises on them.

---
 rtl/pixel_pkg.sv | 23 ++
 rtl/pixel_coord_counter.sv | 59 +++++
 rtl/pixel_unpacker.sv | 174 +++++++++++++++++
 tb/tb_pixel_unpacker.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the packed 24-bit pixel stream: phase encoding,
// default frame geometry and byte-lane positions within a pixel.
package pixel_pkg;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

    localparam int DEFAULT_X_SIZE = 640;
    localparam int DEFAULT_Y_SIZE = 480;

    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input int lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// x/y raster counters with line/frame wrap, forced resync to the origin,
// forced end-of-line, and sof/eol decode of the pixel being issued.
module pixel_coord_counter
    import pixel_pkg::*;
#(
    parameter int X_SIZE = DEFAULT_X_SIZE,
    parameter int Y_SIZE = DEFAULT_Y_SIZE,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          resync,
    input  logic          line_end,
    output logic [CW-1:0] cur_x,
    output logic [CW-1:0] cur_y,
    output logic          at_origin,
    output logic          sof,
    output logic          eol
);

    localparam logic [CW-1:0] X_LAST = CW'(X_SIZE - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(Y_SIZE - 1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    // cur_x/cur_y are the coordinates of the pixel issued this cycle.
    assign cur_x     = resync ? '0 : x_q;
    assign cur_y     = resync ? '0 : y_q;
    assign at_origin = (x_q == '0) && (y_q == '0);
    assign sof       = (cur_x == '0) && (cur_y == '0);
    assign eol       = (cur_x == X_LAST) || line_end;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (step) begin
            if (eol) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_unpacker.sv
// AXI-Stream slave that unpacks 4 pixels from every 3 words of packed 24-bit
// RGB, tags them with raster coordinates and checks the tuser/tlast framing.
module pixel_unpacker
    import pixel_pkg::*;
#(
    parameter int X_SIZE = DEFAULT_X_SIZE,
    parameter int Y_SIZE = DEFAULT_Y_SIZE,
    parameter int CW     = 10
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [31:0]   in_stream_tdata,
    input  logic [3:0]    in_stream_tkeep,
    input  logic          in_stream_tlast,
    input  logic          in_stream_tuser,
    input  logic          in_stream_tvalid,
    output logic          in_stream_tready,
    output logic [7:0]    pix_r,
    output logic [7:0]    pix_g,
    output logic [7:0]    pix_b,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_sof,
    output logic          pix_eol,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          err_sync
);

    // The line's final word is the P2 word of its last 4-pixel group.
    localparam logic [CW-1:0] LAST_WORD_X = CW'(X_SIZE - 2);

    phase_e phase_q, phase_d, eff_phase, phase_next;
    logic [23:0] res_q, res_d, res_next;
    logic [7:0]  r_next, g_next, b_next;

    logic [7:0]    pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
    logic          pix_valid_q, pix_valid_d, err_q, err_d;

    logic          slot_free, word_acc, resync, emit;
    logic          last_word, early_last, missing_last, sync_err;
    logic [CW-1:0] cur_x, cur_y;
    logic          at_origin, coord_sof, coord_eol;
    logic          keep_unused;

    assign keep_unused = &in_stream_tkeep;

    assign slot_free        = !pix_valid_q || pix_ready;
    assign in_stream_tready = !areset && (phase_q != P3) && slot_free;
    assign word_acc         = in_stream_tvalid && in_stream_tready;
    assign resync           = word_acc && in_stream_tuser;
    assign emit             = word_acc || ((phase_q == P3) && slot_free);
    assign eff_phase        = resync ? P0 : phase_q;
    assign last_word        = (eff_phase == P2) && (cur_x == LAST_WORD_X);
    assign early_last       = word_acc && in_stream_tlast && !last_word;
    assign missing_last     = word_acc && !in_stream_tlast && last_word;
    assign sync_err         = resync && ((phase_q != P0) || !at_origin);

    pixel_coord_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE),
        .CW     (CW)
    ) u_coord (
        .clk       (aclk),
        .rst       (areset),
        .step      (emit),
        .resync    (resync),
        .line_end  (early_last),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .at_origin (at_origin),
        .sof       (coord_sof),
        .eol       (coord_eol)
    );

    always_comb begin
        b_next     = res_q[7:0];
        g_next     = res_q[15:8];
        r_next     = res_q[23:16];
        res_next   = '0;
        phase_next = P0;
        case (eff_phase)
            P0: begin
                b_next     = lane_byte(in_stream_tdata, LANE_B);
                g_next     = lane_byte(in_stream_tdata, LANE_G);
                r_next     = lane_byte(in_stream_tdata, LANE_R);
                res_next   = {16'h0000, in_stream_tdata[31:24]};
                phase_next = P1;
            end
            P1: begin
                g_next     = in_stream_tdata[7:0];
                r_next     = in_stream_tdata[15:8];
                res_next   = {8'h00, in_stream_tdata[31:16]};
                phase_next = P2;
            end
            P2: begin
                r_next     = in_stream_tdata[7:0];
                res_next   = in_stream_tdata[31:8];
                phase_next = P3;
            end
            default: begin
                res_next   = '0;
                phase_next = P0;
            end
        endcase

        phase_d     = phase_q;
        res_d       = res_q;
        pix_r_d     = pix_r_q;
        pix_g_d     = pix_g_q;
        pix_b_d     = pix_b_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_sof_d   = pix_sof_q;
        pix_eol_d   = pix_eol_q;
        pix_valid_d = pix_valid_q && !pix_ready;
        err_d       = err_q || sync_err || early_last || missing_last;

        // A misplaced tlast truncates the line, so leftover bytes are dropped.
        if (emit) begin
            phase_d     = early_last ? P0 : phase_next;
            res_d       = early_last ? 24'h0 : res_next;
            pix_r_d     = r_next;
            pix_g_d     = g_next;
            pix_b_d     = b_next;
            pix_x_d     = cur_x;
            pix_y_d     = cur_y;
            pix_sof_d   = coord_sof;
            pix_eol_d   = coord_eol;
            pix_valid_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            phase_q     <= P0;
            res_q       <= '0;
            pix_r_q     <= '0;
            pix_g_q     <= '0;
            pix_b_q     <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            res_q       <= res_d;
            pix_r_q     <= pix_r_d;
            pix_g_q     <= pix_g_d;
            pix_b_q     <= pix_b_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_sof_q   <= pix_sof_d;
            pix_eol_q   <= pix_eol_d;
            pix_valid_q <= pix_valid_d;
            err_q       <= err_d;
        end
    end

    assign pix_r     = pix_r_q;
    assign pix_g     = pix_g_q;
    assign pix_b     = pix_b_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_sof   = pix_sof_q;
    assign pix_eol   = pix_eol_q;
    assign pix_valid = pix_valid_q;
    assign err_sync  = err_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Scoreboard bench for pixel_unpacker on an 8x2 frame: a byte-queue reference
// model predicts pixels at issue time, a monitor pops and compares on handshake.
module tb_pixel_unpacker;

    localparam int X  = 8;
    localparam int Y  = 2;
    localparam int CW = 4;

    logic          aclk;
    logic          areset;
    logic [31:0]   in_stream_tdata;
    logic [3:0]    in_stream_tkeep;
    logic          in_stream_tlast;
    logic          in_stream_tuser;
    logic          in_stream_tvalid;
    logic          in_stream_tready;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic [CW-1:0] pix_x, pix_y;
    logic          pix_sof, pix_eol, pix_valid, pix_ready, err_sync;

    typedef struct {
        logic [7:0]    r, g, b;
        logic [CW-1:0] x, y;
        logic          sof, eol, err;
        bit            p3After;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] modelBytes[$];
    int         modelX, modelY;
    bit         modelErr;
    int         checks, errors;
    int         readyMode;
    bit         gapsOn;

    pixel_unpacker #(.X_SIZE(X), .Y_SIZE(Y), .CW(CW)) dut (
        .aclk             (aclk),
        .areset           (areset),
        .in_stream_tdata  (in_stream_tdata),
        .in_stream_tkeep  (in_stream_tkeep),
        .in_stream_tlast  (in_stream_tlast),
        .in_stream_tuser  (in_stream_tuser),
        .in_stream_tvalid (in_stream_tvalid),
        .in_stream_tready (in_stream_tready),
        .pix_r            (pix_r),
        .pix_g            (pix_g),
        .pix_b            (pix_b),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_sof          (pix_sof),
        .pix_eol          (pix_eol),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .err_sync         (err_sync)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference model: the stream is a flat byte sequence, three bytes per pixel.
    function automatic void modelPixel(input bit forcedEol, input bit p3After);
        exp_t e;
        e.b       = modelBytes.pop_front();
        e.g       = modelBytes.pop_front();
        e.r       = modelBytes.pop_front();
        e.x       = CW'(modelX);
        e.y       = CW'(modelY);
        e.sof     = (modelX == 0) && (modelY == 0);
        e.eol     = (modelX == X - 1) || forcedEol;
        e.err     = modelErr;
        e.p3After = p3After;
        expQ.push_back(e);
        if (e.eol) begin
            modelX = 0;
            modelY = (modelY + 1) % Y;
        end else begin
            modelX = modelX + 1;
        end
    endfunction

    function automatic void modelWord(input logic [31:0] w, input bit u, input bit l);
        int held;
        bit lineWord, badLast;
        held = modelBytes.size();
        if (u) begin
            if (held != 0 || modelX != 0 || modelY != 0) modelErr = 1'b1;
            modelBytes.delete();
            held   = 0;
            modelX = 0;
            modelY = 0;
        end
        lineWord = (held == 2) && (modelX == X - 2);
        badLast  = l && !lineWord;
        if (badLast || (!l && lineWord)) modelErr = 1'b1;
        for (int k = 0; k < 4; k++) modelBytes.push_back(w[8*k +: 8]);
        modelPixel(badLast, (held == 2) && !badLast);
        if (badLast) modelBytes.delete();
        if (modelBytes.size() == 3) modelPixel(1'b0, 1'b0);
    endfunction

    function automatic void modelReset();
        modelBytes.delete();
        expQ.delete();
        modelX   = 0;
        modelY   = 0;
        modelErr = 1'b0;
    endfunction

    task automatic finishNow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Present one word, hold it until accepted, then release the bus.
    task automatic applyStimulus(input logic [31:0] w, input bit u, input bit l);
        int waitCycles;
        modelWord(w, u, l);
        if (gapsOn && $urandom_range(0, 3) == 0) begin
            in_stream_tvalid = 1'b0;
            @(posedge aclk);
            #1;
        end
        in_stream_tdata  = w;
        in_stream_tuser  = u;
        in_stream_tlast  = l;
        in_stream_tvalid = 1'b1;
        waitCycles = 0;
        forever begin
            @(negedge aclk);
            if (in_stream_tready) break;
            waitCycles++;
            if (waitCycles > 500) begin
                checks++;
                errors++;
                $display("[TB] FAIL word_accept_timeout: tready=%0b required 1", in_stream_tready);
                finishNow();
            end
        end
        @(posedge aclk);
        #1;
        in_stream_tvalid = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
    endtask

    task automatic sendFrameWords(input int first, input int lastIdx, input int noLastIdx);
        for (int i = first; i <= lastIdx; i++)
            applyStimulus($urandom, i == 0, (i % 6 == 5) && (i != noLastIdx));
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if ({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, err_sync} !==
            {e.r, e.g, e.b, e.x, e.y, e.sof, e.eol, e.err}) begin
            errors++;
            $display("[TB] FAIL pixel: got rgb=%h%h%h x=%0d y=%0d sof=%0b eol=%0b err=%0b, required rgb=%h%h%h x=%0d y=%0d sof=%0b eol=%0b err=%0b",
                     pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, err_sync,
                     e.r, e.g, e.b, e.x, e.y, e.sof, e.eol, e.err);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checks++;
        if ({in_stream_tready, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y,
             pix_sof, pix_eol, err_sync} !== '0) begin
            errors++;
            $display("[TB] FAIL %s: tready=%0b valid=%0b rgb=%h%h%h x=%0d y=%0d sof=%0b eol=%0b err=%0b, required all 0",
                     name, in_stream_tready, pix_valid, pix_r, pix_g, pix_b,
                     pix_x, pix_y, pix_sof, pix_eol, err_sync);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0) begin
            @(posedge aclk);
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_timeout: %0d pixels outstanding, required 0", expQ.size());
                finishNow();
            end
        end
        @(posedge aclk);
        #1;
    endtask

    // Downstream ready: always high, random, or left to the sequencer.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (readyMode == 0) pix_ready = 1'b1;
            else if (readyMode == 1) pix_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: the queue head is the pixel on display; pop it on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (!areset && pix_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pixel: got rgb=%h%h%h x=%0d y=%0d, required none",
                             pix_r, pix_g, pix_b, pix_x, pix_y);
                end else begin
                    e = expQ[0];
                    checks++;
                    if (in_stream_tready !== (!e.p3After && pix_ready)) begin
                        errors++;
                        $display("[TB] FAIL tready: got %0b required %0b (ready=%0b)",
                                 in_stream_tready, !e.p3After && pix_ready, pix_ready);
                    end
                    if (pix_ready) begin
                        e = expQ.pop_front();
                        checkOutput(e);
                    end
                end
            end
        end
    end

    // Sequencer: reset, clean frames, backpressure, framing faults, mid-frame reset.
    initial begin
        checks           = 0;
        errors           = 0;
        readyMode        = 0;
        gapsOn           = 1'b0;
        in_stream_tdata  = '0;
        in_stream_tkeep  = 4'hF;
        in_stream_tlast  = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tvalid = 1'b0;
        pix_ready        = 1'b1;
        modelReset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checkResetOutputs("reset_state");
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        checks++;
        if (in_stream_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tready_after_reset: got %0b required 1", in_stream_tready);
        end

        $display("[TB] clean frames");
        applyStimulus(32'h44332211, 1'b1, 1'b0);
        applyStimulus(32'h88776655, 1'b0, 1'b0);
        applyStimulus(32'hCCBBAA99, 1'b0, 1'b0);
        sendFrameWords(3, 11, -1);
        sendFrameWords(0, 11, -1);
        waitDrain();

        $display("[TB] backpressure");
        readyMode = 1;
        gapsOn    = 1'b1;
        sendFrameWords(0, 11, -1);
        sendFrameWords(0, 11, -1);
        waitDrain();

        $display("[TB] early tlast");
        sendFrameWords(0, 5, -1);
        applyStimulus($urandom, 1'b0, 1'b1);
        sendFrameWords(0, 11, -1);

        $display("[TB] mid-line tuser");
        sendFrameWords(0, 9, -1);
        applyStimulus($urandom, 1'b1, 1'b0);
        sendFrameWords(1, 11, -1);

        $display("[TB] missing tlast");
        sendFrameWords(0, 11, 5);
        sendFrameWords(0, 11, -1);
        waitDrain();

        $display("[TB] reset mid-frame");
        readyMode = 2;
        gapsOn    = 1'b0;
        @(posedge aclk);
        #2;
        pix_ready = 1'b1;
        applyStimulus($urandom, 1'b1, 1'b0);
        applyStimulus($urandom, 1'b0, 1'b0);
        pix_ready = 1'b0;
        @(negedge aclk);
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_pixel_before_reset: valid=%0b required 1", pix_valid);
        end
        #2;
        areset = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        modelReset();
        @(posedge aclk);
        @(negedge aclk);
        areset    = 1'b0;
        pix_ready = 1'b1;
        @(posedge aclk);
        #1;
        applyStimulus(32'h00FF0000, 1'b1, 1'b0);
        waitDrain();

        finishNow();
    end

endmodule
